// File: rtl/alu_structure_pkg.sv
// Shared ALU types: MIPS opcode list, ALU output bundle, and the op-sequencer
// request/state types.
package alu_structure_pkg;

    typedef enum logic [5:0] {
        SLL   = 6'h00,
        SRL   = 6'h02,
        SRA   = 6'h03,
        MFHI  = 6'h10,
        MFLO  = 6'h12,
        MULT  = 6'h18,
        MULTU = 6'h19,
        DIV   = 6'h1A,
        DIVU  = 6'h1B,
        ADD   = 6'h20,
        ADDU  = 6'h21,
        SUB   = 6'h22,
        SUBU  = 6'h23,
        AND   = 6'h24,
        OR    = 6'h25,
        XOR   = 6'h26,
        NOR   = 6'h27,
        SLT   = 6'h2A,
        SLTU  = 6'h2B
    } opcode_list;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] HI;
        logic [31:0] LO;
        logic        BZero;
        logic        EXC_Ov;
    } aluout;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_t;

    typedef struct packed {
        logic [31:0] A;
        logic [31:0] B;
        opcode_list  opcode;
        logic [4:0]  Shamt;
    } alu_req_t;

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Request queue for the ALU op sequencer: wrap-around pointers plus an
// occupancy count, with a synchronous clear used by pipeline flushes.
module alu_req_fifo
    import alu_structure_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     i_clock,
    input  logic     i_reset,
    input  logic     i_clear,
    input  logic     i_push,
    input  alu_req_t i_data,
    input  logic     i_pop,
    output alu_req_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int            AW    = $clog2(DEPTH);
    localparam logic [AW:0]   FULLC = DEPTH[AW:0];

    alu_req_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == FULLC);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];

    // A pop frees its slot in the same cycle, so push is legal when full+pop.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset && !i_clear) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues queued ALU ops one at a time, holds them across ALU_Stall, and returns
// the captured ALU outputs on a valid/ready response port.
module alu_op_sequencer
    import alu_structure_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_A,
    input  logic [31:0] i_req_B,
    input  opcode_list  i_req_opcode,
    input  logic [4:0]  i_req_Shamt,
    input  logic        i_hold,
    input  logic        i_flush,
    output logic [31:0] o_alu_A,
    output logic [31:0] o_alu_B,
    output opcode_list  o_alu_opcode,
    output logic [4:0]  o_alu_Shamt,
    output logic        o_alu_EX_Stall,
    output logic        o_alu_EX_Flush,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_alu_HI,
    input  logic [31:0] i_alu_LO,
    input  logic        i_alu_BZero,
    input  logic        i_alu_EXC_Ov,
    input  logic        i_alu_ALU_Stall,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_result,
    output logic [31:0] o_rsp_HI,
    output logic [31:0] o_rsp_LO,
    output logic        o_rsp_BZero,
    output logic        o_rsp_EXC_Ov,
    output logic        o_seq_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    alu_req_t      w_req;
    alu_req_t      w_head;
    alu_req_t      r_op;
    alu_req_t      w_drive;
    aluout         r_rsp;
    logic          r_rsp_valid;
    logic          r_seq_err;
    logic [CW-1:0] r_wait_cnt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_have;
    logic          w_capture;
    logic          w_wdog;
    logic          w_flush_all;

    assign w_req = '{A: i_req_A, B: i_req_B, opcode: i_req_opcode, Shamt: i_req_Shamt};

    // Watchdog acts exactly like an external flush; reset suppresses both.
    assign w_wdog      = (r_state == WAIT) && (r_wait_cnt == CW'(MAX_WAIT));
    assign w_flush_all = !i_reset && (i_flush || w_wdog);
    assign o_req_ready = !i_reset && !w_full && !w_flush_all;
    assign w_push      = i_req_valid && o_req_ready;
    // Counting an in-flight push lets IDLE issue on the cycle after acceptance.
    assign w_have      = !w_empty || w_push;

    alu_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_flush_all),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE:  if (w_have && !i_hold && !r_rsp_valid) w_next = ISSUE;
            ISSUE: begin
                w_pop  = 1'b1;
                w_next = WAIT;
            end
            WAIT:  if (!i_alu_ALU_Stall && !i_hold) begin
                w_capture = 1'b1;
                w_next    = RESP;
            end
            RESP:  if (r_rsp_valid && i_rsp_ready)
                       w_next = (w_have && !i_hold) ? ISSUE : IDLE;
            default: w_next = IDLE;
        endcase
        if (w_flush_all) begin
            w_next    = IDLE;
            w_pop     = 1'b0;
            w_capture = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_wait_cnt  <= '0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ISSUE) r_op <= w_head;
            if (r_state == WAIT && w_next == WAIT && i_alu_ALU_Stall)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else if (w_next != WAIT)
                r_wait_cnt <= '0;
            if (w_capture) begin
                r_rsp       <= '{result: i_alu_result, HI: i_alu_HI, LO: i_alu_LO,
                                 BZero: i_alu_BZero, EXC_Ov: i_alu_EXC_Ov};
                r_rsp_valid <= 1'b1;
            end else if (w_flush_all || i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_wdog) r_seq_err <= 1'b1;
        end
    end

    // ISSUE drives the FIFO head directly; WAIT replays the latched copy.
    always_comb begin
        w_drive = '0;
        if (!i_reset) begin
            case (r_state)
                ISSUE:   w_drive = w_head;
                WAIT:    w_drive = r_op;
                default: w_drive = '0;
            endcase
        end
    end

    assign o_alu_A        = w_drive.A;
    assign o_alu_B        = w_drive.B;
    assign o_alu_opcode   = w_drive.opcode;
    assign o_alu_Shamt    = w_drive.Shamt;
    assign o_alu_EX_Stall = !i_reset && i_hold && (r_state == ISSUE || r_state == WAIT);
    assign o_alu_EX_Flush = w_flush_all;

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp.result;
    assign o_rsp_HI     = r_rsp.HI;
    assign o_rsp_LO     = r_rsp.LO;
    assign o_rsp_BZero  = r_rsp.BZero;
    assign o_rsp_EXC_Ov = r_rsp.EXC_Ov;
    assign o_seq_err    = r_seq_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the bench plays the ALU and the consumer.
module tb_alu_op_sequencer;
    import alu_structure_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_A, req_B;
    opcode_list  req_opcode;
    logic [4:0]  req_Shamt;
    logic        hold, flush;
    logic [31:0] alu_A, alu_B;
    opcode_list  alu_opcode;
    logic [4:0]  alu_Shamt;
    logic        alu_EX_Stall, alu_EX_Flush;
    logic [31:0] alu_result, alu_HI, alu_LO;
    logic        alu_BZero, alu_EXC_Ov, alu_ALU_Stall;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result, rsp_HI, rsp_LO;
    logic        rsp_BZero, rsp_EXC_Ov;
    logic        seq_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.QDEPTH(4), .MAX_WAIT(64)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_A(req_A), .i_req_B(req_B), .i_req_opcode(req_opcode), .i_req_Shamt(req_Shamt),
        .i_hold(hold), .i_flush(flush),
        .o_alu_A(alu_A), .o_alu_B(alu_B), .o_alu_opcode(alu_opcode), .o_alu_Shamt(alu_Shamt),
        .o_alu_EX_Stall(alu_EX_Stall), .o_alu_EX_Flush(alu_EX_Flush),
        .i_alu_result(alu_result), .i_alu_HI(alu_HI), .i_alu_LO(alu_LO),
        .i_alu_BZero(alu_BZero), .i_alu_EXC_Ov(alu_EXC_Ov), .i_alu_ALU_Stall(alu_ALU_Stall),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_HI(rsp_HI), .o_rsp_LO(rsp_LO),
        .o_rsp_BZero(rsp_BZero), .o_rsp_EXC_Ov(rsp_EXC_Ov),
        .o_seq_err(seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                             input opcode_list op);
        req_valid  = v;
        req_A      = a;
        req_B      = b;
        req_opcode = op;
        req_Shamt  = 5'd0;
    endtask

    initial begin
        int k;
        int pulses;
        int bad;

        rst = 1'b1; hold = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        drive_req(1'b0, 32'd0, 32'd0, ADD);
        alu_result = '0; alu_HI = '0; alu_LO = '0;
        alu_BZero = 1'b0; alu_EXC_Ov = 1'b0; alu_ALU_Stall = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_alu_A", alu_A, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1);

        // ADD 5+7: accept at N, ISSUE N+1, capture N+2, response N+3
        drive_req(1'b1, 32'd5, 32'd7, ADD);
        tick();
        req_valid = 1'b0;
        alu_result = 32'd12;
        chk("add_issue_A", alu_A, 5);
        chk("add_issue_B", alu_B, 7);
        chk("add_issue_op", alu_opcode, ADD);
        tick();
        chk("add_wait_rsp_valid", rsp_valid, 0);
        tick();
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_rsp_result", rsp_result, 12);
        chk("add_seq_err", seq_err, 0);
        chk("add_resp_alu_A", alu_A, 0);
        tick();
        chk("add_consumed", rsp_valid, 0);

        // MULT 0x10000*0x30000 with a 10-cycle ALU stall
        drive_req(1'b1, 32'h0001_0000, 32'h0003_0000, MULT);
        tick();
        req_valid = 1'b0;
        alu_ALU_Stall = 1'b1;
        alu_HI = 32'd3; alu_LO = 32'd0;
        chk("mult_issue_op", alu_opcode, MULT);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                hold = 1'b1;
                #1;
                chk("mult_ex_stall", alu_EX_Stall, 1);
                hold = 1'b0;
            end
            if (alu_A !== 32'h0001_0000 || alu_B !== 32'h0003_0000 || rsp_valid !== 1'b0) bad++;
        end
        chk("mult_stable_cycles_bad", bad, 0);
        alu_ALU_Stall = 1'b0;
        tick();
        chk("mult_rsp_valid", rsp_valid, 1);
        chk("mult_rsp_HI", rsp_HI, 3);
        chk("mult_rsp_LO", rsp_LO, 0);
        tick();

        // Fill queue under hold; 5th push refused; order kept across wrap
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b1, 32'(100 + i), 32'd1, ADDU);
            #1;
            chk($sformatf("fill_ready_%0d", i), req_ready, (i < 4) ? 1 : 0);
            tick();
        end
        req_valid = 1'b0;
        chk("fill_no_issue", alu_A, 0);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain_order_%0d", i), alu_A, 32'(100 + i));
            tick();
            tick();
        end
        tick();
        chk("drain_idle_alu_A", alu_A, 0);
        chk("drain_idle_rsp", rsp_valid, 0);

        // Response back-pressure for 20 cycles
        rsp_ready = 1'b0;
        drive_req(1'b1, 32'd200, 32'd0, ADD);
        tick();
        req_A = 32'd201;
        alu_result = 32'h0000_ABCD;
        tick();
        req_valid = 1'b0;
        tick();
        alu_result = 32'h0000_DEAD;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_ABCD || alu_A !== 32'd0) bad++;
            tick();
        end
        chk("bp_held_bad", bad, 0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_next_issue_A", alu_A, 201);
        chk("bp_rsp_cleared", rsp_valid, 0);
        tick(); tick(); tick();

        // Flush while WAIT with 3 queued
        drive_req(1'b1, 32'd300, 32'd0, SUB);
        tick();
        alu_ALU_Stall = 1'b1;
        req_A = 32'd301;
        tick();
        req_A = 32'd302;
        tick();
        req_A = 32'd303;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_pulse", alu_EX_Flush, 1);
        chk("flush_ready_low", req_ready, 0);
        pulses = 1;
        tick();
        flush = 1'b0;
        alu_ALU_Stall = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (alu_EX_Flush) pulses++;
            if (alu_A !== 32'd0 || rsp_valid !== 1'b0) bad++;
            tick();
        end
        chk("flush_pulse_count", pulses, 1);
        chk("flush_dropped_bad", bad, 0);

        // Watchdog: ALU_Stall stuck high
        drive_req(1'b1, 32'd400, 32'd0, DIV);
        tick();
        req_valid = 1'b0;
        alu_ALU_Stall = 1'b1;
        k = 0;
        pulses = 0;
        while (k < 200 && seq_err !== 1'b1) begin
            tick();
            k++;
            if (alu_EX_Flush) pulses++;
        end
        chk("wdog_cycles", k, 66);
        chk("wdog_flush_pulses", pulses, 1);
        chk("wdog_alu_A", alu_A, 0);
        chk("wdog_rsp_valid", rsp_valid, 0);

        // Reset during WAIT clears the error without a flush pulse
        drive_req(1'b1, 32'd500, 32'd0, ADD);
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstwait_in_wait_A", alu_A, 500);
        rst = 1'b1;
        #1;
        chk("rstwait_no_flush", alu_EX_Flush, 0);
        tick();
        rst = 1'b0;
        alu_ALU_Stall = 1'b0;
        #1;
        chk("rstwait_seq_err", seq_err, 0);
        chk("rstwait_rsp_valid", rsp_valid, 0);
        tick();
        chk("rstwait_no_issue", alu_A, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
